// File: rtl/simple_dma_controller_pkg.sv
// rtl/simple_dma_controller_pkg.sv - shared state encodings, direction and device CONFIG constants
package simple_dma_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DEV = 3'd1,
        ST_DEV_LAT  = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_RD   = 3'd4,
        ST_ACK      = 3'd5,
        ST_DONE     = 3'd6
    } dma_state_t;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    // Bit positions of the device CONFIG register, shared with simple_dma_device
    localparam int CFG_START      = 0;
    localparam int CFG_RD_WR      = 2;
    localparam int CFG_NON_ATOMIC = 3;
    localparam int CFG_ACK_SET    = 4;
    localparam int CFG_RESET_REGS = 5;
    localparam int CFG_END_OP     = 15;

endpackage

// File: rtl/simple_dma_xfer_cnt.sv
// rtl/simple_dma_xfer_cnt.sv - word address register with wrap and remaining-word counter
module simple_dma_xfer_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic        dec,
    input  logic [14:0] addr_in,
    input  logic [15:0] count_in,
    output logic [14:0] addr,
    output logic        zero
);

    logic [14:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = addr_in;
            cnt_d  = count_in;
        end else begin
            // 15-bit add wraps 0x7FFF -> 0x0000 naturally
            if (inc) addr_d = addr_q + 15'd1;
            if (dec) cnt_d  = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/simple_dma_controller.sv
// rtl/simple_dma_controller.sv - word-at-a-time DMA engine between simple_dma_device and the core DMA port
module simple_dma_controller
    import simple_dma_controller_pkg::*;
#(
    parameter logic PRIORITY  = 1'b0,
    parameter logic ERR_ABORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_error,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    output logic        mem_priority,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready,
    input  logic        mem_resp
);

    dma_state_t  state_q, state_d;
    logic        dir_q, dir_d;
    logic        err_q, err_d;
    logic        ack_q, ack_d;
    logic        end_q, end_d;
    logic        mem_en_q, mem_en_d;
    logic [1:0]  mem_we_q, mem_we_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [15:0] dev_in_q, dev_in_d;

    logic        cnt_load, cnt_inc, cnt_dec, cnt_zero;
    logic [14:0] cur_addr;
    logic        xfer_done;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = dma_start_address[0];

    simple_dma_xfer_cnt u_xfer_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .addr_in  (dma_start_address[15:1]),
        .count_in (dma_num_words),
        .addr     (cur_addr),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        err_d     = err_q;
        cnt_load  = 1'b0;
        xfer_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_rqst) begin
                    cnt_load = 1'b1;
                    dir_d    = dma_rd_wr;
                    err_d    = 1'b0;
                    state_d  = (dma_num_words == 16'd0) ? ST_DONE : ST_WAIT_DEV;
                end
            end
            ST_WAIT_DEV: begin
                if (!dma_rqst)    state_d = ST_IDLE;
                else if (dev_ack) state_d = ST_DEV_LAT;
            end
            ST_DEV_LAT: state_d = dma_rqst ? ST_MEM_REQ : ST_IDLE;
            ST_MEM_REQ: begin
                if (mem_ready) begin
                    if (dir_q == DIR_RD) state_d = ST_MEM_RD;
                    else                 xfer_done = 1'b1;
                end
            end
            ST_MEM_RD: xfer_done = 1'b1;
            ST_ACK:    state_d = cnt_zero ? ST_DONE : ST_WAIT_DEV;
            ST_DONE:   if (!dma_rqst) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A completed access always finishes; a withdrawn request skips the ACK
        if (xfer_done) begin
            if (mem_resp) err_d = 1'b1;
            if (!dma_rqst)                  state_d = ST_IDLE;
            else if (mem_resp && ERR_ABORT) state_d = ST_DONE;
            else                            state_d = ST_ACK;
        end
    end

    assign cnt_inc = (state_q == ST_ACK);
    assign cnt_dec = (state_d == ST_ACK) && (state_q != ST_ACK);

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        ack_d      = (state_d == ST_ACK);
        end_d      = (state_d == ST_DONE);
        mem_en_d   = (state_d == ST_MEM_REQ);
        mem_addr_d = (state_d == ST_MEM_REQ) ? cur_addr : 15'd0;
        mem_we_d   = ((state_d == ST_MEM_REQ) && (dir_q == DIR_WR)) ? 2'b11 : 2'b00;
        mem_din_d  = 16'd0;
        if (state_d == ST_MEM_REQ) begin
            mem_din_d = ((state_q == ST_DEV_LAT) && (dir_q == DIR_WR)) ? dev_out : mem_din_q;
        end
        dev_in_d = dev_in_q;
        if (state_q == ST_MEM_RD) dev_in_d = mem_dout;
        if (state_d == ST_IDLE)   dev_in_d = 16'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_WR;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            end_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 2'b00;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            dev_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            end_q      <= end_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            dev_in_q   <= dev_in_d;
        end
    end

    assign dev_in       = dev_in_q;
    assign dma_ack      = ack_q;
    assign dma_end_flag = end_q;
    assign dma_error    = err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_priority = (state_q != ST_IDLE) ? PRIORITY : 1'b0;

endmodule

// File: tb/tb_simple_dma_controller.sv
// tb/tb_simple_dma_controller.sv - scoreboard bench for simple_dma_controller
module tb_simple_dma_controller;

    localparam int K_MEM = 1;
    localparam int K_ACK = 2;
    localparam int K_END = 3;

    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] data;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error;
    logic [14:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic        mem_priority;
    logic [15:0] mem_dout;
    logic        mem_ready;
    logic        mem_resp;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    logic [15:0] rd_data [4];
    logic [15:0] wr_data [4];
    int          rd_idx = 0;
    int          err_idx = -1;
    int          wr_idx = 0;
    int          stall_left = 0;
    bit          rd_hold = 1'b0;
    bit          end_prev = 1'b0;
    bit          ack_prev = 1'b0;

    simple_dma_controller #(.PRIORITY(1'b1), .ERR_ABORT(1'b1)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dev_ack           (dev_ack),
        .dev_out           (dev_out),
        .dev_in            (dev_in),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .dma_error         (dma_error),
        .mem_addr          (mem_addr),
        .mem_din           (mem_din),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_priority      (mem_priority),
        .mem_dout          (mem_dout),
        .mem_ready         (mem_ready),
        .mem_resp          (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_%s: DUT produced an event, expected none (queue empty)", name);
    endtask

    task automatic push(input int kind, input logic [14:0] addr, input logic [1:0] we,
                        input logic [15:0] data, input logic chk);
        exp_t e;
        e.kind = kind; e.addr = addr; e.we = we; e.data = data; e.chk = chk;
        sb.push_back(e);
    endtask

    // Memory/device responder followed by the scoreboard monitor, all on the falling edge
    initial begin
        exp_t e;
        mem_ready = 1'b1;
        mem_dout  = 16'h0;
        mem_resp  = 1'b0;
        dev_out   = 16'h0;
        forever begin
            @(negedge clk);
            mem_ready = (stall_left == 0);
            if (mem_en && stall_left > 0) stall_left--;
            if (rd_hold) rd_hold = 1'b0;
            else         mem_resp = 1'b0;
            if (mem_en && mem_ready && mem_we == 2'b00) begin
                mem_dout = rd_data[rd_idx & 3];
                mem_resp = (rd_idx == err_idx);
                rd_idx++;
                rd_hold = 1'b1;
            end
            if (dma_ack) wr_idx++;
            dev_out = wr_data[wr_idx & 3];

            if (mem_en) begin
                if (sb.size() == 0) unexpected("mem_access");
                else begin
                    e = sb[0];
                    check(mem_ready ? "mem_access" : "mem_stall_hold",
                          64'({4'(K_MEM), mem_addr, mem_we, mem_din}),
                          64'({4'(e.kind), e.addr, e.we, e.chk ? e.data : mem_din}));
                    if (mem_ready) void'(sb.pop_front());
                end
            end
            if (dma_ack) begin
                if (sb.size() == 0) unexpected("dma_ack");
                else begin
                    e = sb.pop_front();
                    check("dma_ack_dev_in", 64'({4'(K_ACK), dev_in}),
                          64'({4'(e.kind), e.chk ? e.data : dev_in}));
                end
            end
            if (dma_end_flag && !end_prev) begin
                if (sb.size() == 0) unexpected("end_flag");
                else begin
                    e = sb.pop_front();
                    check("end_flag_err_after_ack", 64'({4'(K_END), dma_error, ack_prev}),
                          64'({4'(e.kind), e.data[0], e.data[1]}));
                end
            end
            end_prev = dma_end_flag;
            ack_prev = dma_ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string name, input logic err, input bit full);
        if (full)
            check(name, 64'({dev_in, dma_ack, dma_end_flag, dma_error, mem_addr, mem_din,
                             mem_en, mem_we, mem_priority}),
                  64'({16'h0, 1'b0, 1'b0, err, 15'h0, 16'h0, 1'b0, 2'b00, 1'b0}));
        else
            check(name, 64'({dma_ack, dma_end_flag, dma_error, mem_en, mem_we, mem_priority}),
                  64'({1'b0, 1'b0, err, 1'b0, 2'b00, 1'b0}));
    endtask

    task automatic request(input logic rd_wr, input logic [15:0] addr, input logic [15:0] n);
        dma_rd_wr = rd_wr;
        dma_start_address = addr;
        dma_num_words = n;
        dma_rqst = 1'b1;
    endtask

    task automatic wait_end(input string name, output int cycles);
        cycles = 0;
        while (!dma_end_flag && cycles < 300) begin
            tick();
            cycles++;
        end
        check(name, 64'(dma_end_flag), 64'd1);
    endtask

    task automatic wait_mem_en(input string name, output int cycles);
        cycles = 0;
        while (!mem_en && cycles < 50) begin
            tick();
            cycles++;
        end
        check(name, 64'(mem_en), 64'd1);
    endtask

    task automatic finish_xfer(input string name, input logic err);
        dma_rqst = 1'b0;
        tick();
        check_idle(name, err, 1'b0);
    endtask

    initial begin
        int c;
        reset_n = 1'b0;
        dma_rqst = 1'b0;
        dma_rd_wr = 1'b0;
        dma_start_address = 16'h0;
        dma_num_words = 16'h0;
        dev_ack = 1'b0;
        rd_data = '{16'h0, 16'h0, 16'h0, 16'h0};
        wr_data = '{16'h0, 16'h0, 16'h0, 16'h0};
        repeat (3) tick();
        check_idle("reset_state", 1'b0, 1'b1);
        reset_n = 1'b1;
        tick();
        dev_ack = 1'b1;

        // Read 3 words from 0x0200
        rd_data = '{16'hA001, 16'hA002, 16'hA003, 16'h0};
        rd_idx = 0; err_idx = -1; wr_idx = 0;
        push(K_MEM, 15'h100, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hA001, 1'b1);
        push(K_MEM, 15'h101, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hA002, 1'b1);
        push(K_MEM, 15'h102, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hA003, 1'b1);
        push(K_END, 15'h0, 2'b00, 16'h2, 1'b1);
        request(1'b1, 16'h0200, 16'd3);
        wait_mem_en("rd3_mem_en_seen", c);
        check("rd3_first_mem_en_latency", 64'(c), 64'd3);
        wait_end("rd3_end_seen", c);
        finish_xfer("rd3_idle", 1'b0);

        // Write 2 words to 0x0300 with a 2-cycle stall on the first access
        wr_data = '{16'h1234, 16'h5678, 16'h0, 16'h0};
        wr_idx = 0; stall_left = 2;
        push(K_MEM, 15'h180, 2'b11, 16'h1234, 1'b1); push(K_ACK, 15'h0, 2'b00, 16'h0, 1'b0);
        push(K_MEM, 15'h181, 2'b11, 16'h5678, 1'b1); push(K_ACK, 15'h0, 2'b00, 16'h0, 1'b0);
        push(K_END, 15'h0, 2'b00, 16'h2, 1'b1);
        request(1'b0, 16'h0300, 16'd2);
        wait_end("wr2_end_seen", c);
        finish_xfer("wr2_idle", 1'b0);

        // Address wrap from 0xFFFE
        rd_data = '{16'hB001, 16'hB002, 16'h0, 16'h0};
        rd_idx = 0; wr_idx = 0;
        push(K_MEM, 15'h7FFF, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hB001, 1'b1);
        push(K_MEM, 15'h0000, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hB002, 1'b1);
        push(K_END, 15'h0, 2'b00, 16'h2, 1'b1);
        request(1'b1, 16'hFFFE, 16'd2);
        wait_end("wrap_end_seen", c);
        finish_xfer("wrap_idle", 1'b0);

        // Error response on the second of four reads aborts the transfer
        rd_data = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        rd_idx = 0; err_idx = 1; wr_idx = 0;
        push(K_MEM, 15'h200, 2'b00, 16'h0, 1'b0); push(K_ACK, 15'h0, 2'b00, 16'hC001, 1'b1);
        push(K_MEM, 15'h201, 2'b00, 16'h0, 1'b0);
        push(K_END, 15'h0, 2'b00, 16'h1, 1'b1);
        request(1'b1, 16'h0400, 16'd4);
        wait_end("err_end_seen", c);
        finish_xfer("err_idle_sticky", 1'b1);
        err_idx = -1;

        // Zero-length request: end flag next cycle, error cleared, no access
        push(K_END, 15'h0, 2'b00, 16'h0, 1'b1);
        request(1'b0, 16'h0000, 16'd0);
        wait_end("zero_end_seen", c);
        check("zero_end_latency", 64'(c), 64'd1);
        finish_xfer("zero_idle", 1'b0);

        // Request withdrawn while waiting on the device
        dev_ack = 1'b0;
        request(1'b1, 16'h0600, 16'd2);
        tick();
        check("prio_in_wait_dev", 64'(mem_priority), 64'd1);
        dma_rqst = 1'b0;
        tick();
        check_idle("idle_after_withdraw", 1'b0, 1'b1);
        repeat (3) tick();
        dev_ack = 1'b1;

        // Reset while an access is stalled in MEM_REQ
        wr_data = '{16'h9999, 16'h0, 16'h0, 16'h0};
        wr_idx = 0; stall_left = 10;
        push(K_MEM, 15'h280, 2'b11, 16'h9999, 1'b1);
        request(1'b0, 16'h0500, 16'd1);
        wait_mem_en("rst_mem_en_seen", c);
        tick();
        reset_n = 1'b0;
        dma_rqst = 1'b0;
        tick();
        check_idle("idle_in_reset", 1'b0, 1'b1);
        reset_n = 1'b1;
        stall_left = 0;
        sb.delete();
        tick();
        check_idle("idle_after_reset", 1'b0, 1'b1);

        repeat (4) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
